snoop_bus_ctrl: RTL
===================

# snoop_bus_ctrl

Parametrised snooping-bus controller for the MSI-coherent multicore: arbitrates coherence requests from `NUM_CPU` private data caches, broadcasts snoops, chooses whether a missing block comes from a peer cache or from dmem, and sequences write-backs and invalidations. It sits between the per-core cache controllers and the shared dmem port. It generalises the two-core bus to N cores with:

- latched transactions
- multi-cycle snoop and memory phases
- dirty-owner write-back
- a completion handshake

## Interface
Parameters:
- `NUM_CPU`, 4, number of cores (2..8)
- `ADDR_W`, 11, full block address width
- `SNOOP_CYCLES`, 2, cycles peers get to answer a snoop (≥1)
- `MEM_CYCLES`, 4, dmem read or write-back latency (≥1)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  `NUM_CPU`  per-core request; held until `done`
- `req_op`  in  `2*NUM_CPU`  per-core op: 00 read miss, 01 write miss, 10 invalidate, 11 reserved
- `req_addr`  in  `NUM_CPU*ADDR_W`  per-core address
- `snoop_hit`  in  `NUM_CPU`  peer holds a valid copy of `addr_out`
- `snoop_dirty`  in  `NUM_CPU`  peer holds it Modified
- `grant`  out  `NUM_CPU`  one-hot owner of the bus
- `addr_out`  out  `ADDR_W`  latched transaction address
- `snoop`  out  `NUM_CPU`  search request to every non-owner
- `datasel`  out  `NUM_CPU`  fill source for the owner: 1 = peer, 0 = dmem
- `fwd_src`  out  `$clog2(NUM_CPU)`  index of the forwarding peer
- `invalidate_tag`  out  `NUM_CPU`  invalidate `addr_out`
- `wback_dmem`  out  `NUM_CPU`  write the block to dmem
- `done`  out  `NUM_CPU`  one-cycle completion pulse to the owner
- `busy`  out  1  state ≠ IDLE

## Operation
- **States:** IDLE, SNOOP, FWD, WB, MEM, INV, DONE.
- **IDLE**
  - If any `req` is set: select a winner and latch its index, op and address.
  - Next state: SNOOP for read or write miss, INV for invalidate, DONE for reserved.
- **SNOOP**
  - `snoop` = ~`grant`.
  - Cycle counter runs `SNOOP_CYCLES` cycles.
  - On the last cycle, sample `hit` = |(`snoop_hit` & ~`grant`) and `dirty` likewise.
  - `fwd_src` = lowest-index hitting peer, latched.
- **Read miss**
  - If `hit`: go to FWD.
  - Otherwise: go to MEM.
- **Write miss**
  - If `dirty`: go to WB.
  - Otherwise: go to MEM.
- **FWD** (1 cycle)
  - `datasel`[owner] = 1.
  - If `dirty`: `wback_dmem`[`fwd_src`] = 1 (the owner downgrades to Shared).
  - Next state: DONE.
- **WB** (`MEM_CYCLES` cycles)
  - `wback_dmem`[`fwd_src`] = 1.
  - Next state: MEM.
- **MEM** (`MEM_CYCLES` cycles)
  - `datasel`[owner] = 0.
  - Next state: DONE.
- **INV** (1 cycle)
  - `invalidate_tag` = ~`grant`.
  - `wback_dmem`[owner] = 1.
  - Next state: DONE.
- **DONE** (1 cycle)
  - `done`[owner] = 1.
  - For a write miss, `invalidate_tag` = ~`grant`.
  - Next state: IDLE.
- `grant` is valid in every state except IDLE.
- `addr_out` holds the latched address from SNOOP/INV through DONE.
- Requester rules:
  - A requester deasserts `req` on the edge ending DONE.
  - `req` falling mid-transaction is ignored; the transaction completes.
  - Inputs of the owner are not re-sampled after IDLE.
- More than one `snoop_dirty` is illegal; the lowest index is used.

## Timing
- **Reset values:** all outputs 0, `addr_out` = 0, state IDLE, counter 0, round-robin pointer `NUM_CPU`-1.
- **Reset mid-transaction:** aborts immediately; no `done` is issued.
- **Latency** from the `req`-sampled cycle (c0) to `done`, writing S = `SNOOP_CYCLES` and M = `MEM_CYCLES`:
  - read hit: c(S+2)
  - read miss: c(S+M+1)
  - write miss, clean: c(S+M+1)
  - write miss, dirty: c(S+2M+1)
  - invalidate: c2
  - reserved op: c1
- The next arbitration happens at the earliest in the cycle after DONE, so there is a minimum 1 idle cycle between transactions.
- Simultaneous requests: one winner per IDLE cycle; losers keep `req` asserted and wait.
- Counter width is `$clog2(max(S,M)+1)`. It reloads on every state entry and never wraps inside a phase.

## Configuration
- **`SNOOP_BUS_RR_EN` defined:** round-robin arbitration.
  - Search starts at (last winner + 1) mod `NUM_CPU`.
  - The pointer updates when a winner is latched.
- **`SNOOP_BUS_RR_EN` undefined:** fixed priority, lowest index wins.
  - The pointer logic is removed.

## Test plan
- **Read hit, clean peer:**
  - Stimulus: cpu1 read miss at 0x2A5; cpu3 `snoop_hit`.
  - Response: `grant`=0010, `snoop`=1101 for 2 cycles, FWD with `datasel`[1]=1 and `fwd_src`=3, `done`[1] at c4, no `wback_dmem`.
- **Read miss, no hit:**
  - Stimulus: cpu0 read miss; no `snoop_hit`.
  - Response: MEM for 4 cycles with `datasel`[0]=0, `done`[0] at c7.
- **Write miss, dirty peer:**
  - Stimulus: cpu2 write miss; cpu0 `snoop_hit` and `snoop_dirty`.
  - Response: `wback_dmem`[0] for 4 cycles, MEM for 4 cycles, DONE with `invalidate_tag`=1011 and `done`[2] at c11.
- **Simultaneous requests:**
  - Stimulus: all four `req` high from reset.
  - Response with `SNOOP_BUS_RR_EN` defined: grant order 0, 1, 2, 3.
  - Response without it: cpu0 is granted; after it drops `req`, cpu1 is granted.
- **Invalidate:**
  - Stimulus: cpu3 invalidate.
  - Response: INV with `invalidate_tag`=0111 and `wback_dmem`[3]=1, `done`[3] at c2.
- **Reset mid-transaction:**
  - Stimulus: `rst_n` low during MEM.
  - Response: all outputs 0 immediately, `busy`=0, no `done`.

Source files
------------

// File: rtl/snoop_bus_ctrl.sv
// MSI snooping-bus controller for NUM_CPU private caches: arbitration, snoop, forward/dmem fill,
// write-back and invalidation sequencing. Define SNOOP_BUS_RR_EN for round-robin arbitration.
module snoop_bus_ctrl #(
  parameter int NUM_CPU      = 4,
  parameter int ADDR_W       = 11,
  parameter int SNOOP_CYCLES = 2,
  parameter int MEM_CYCLES   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CPU-1:0]           req,
  input  logic [2*NUM_CPU-1:0]         req_op,
  input  logic [NUM_CPU*ADDR_W-1:0]    req_addr,
  input  logic [NUM_CPU-1:0]           snoop_hit,
  input  logic [NUM_CPU-1:0]           snoop_dirty,
  output logic [NUM_CPU-1:0]           grant,
  output logic [ADDR_W-1:0]            addr_out,
  output logic [NUM_CPU-1:0]           snoop,
  output logic [NUM_CPU-1:0]           datasel,
  output logic [$clog2(NUM_CPU)-1:0]   fwd_src,
  output logic [NUM_CPU-1:0]           invalidate_tag,
  output logic [NUM_CPU-1:0]           wback_dmem,
  output logic [NUM_CPU-1:0]           done,
  output logic                         busy
);

  localparam int IW   = $clog2(NUM_CPU);
  localparam int MAXC = (SNOOP_CYCLES > MEM_CYCLES) ? SNOOP_CYCLES : MEM_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SNOOP, S_FWD, S_WB, S_MEM, S_INV, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_INV = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IW-1:0]       fwd_q, fwd_d;
  logic                dirty_q, dirty_d;

  logic [NUM_CPU-1:0]  grant_q, grant_d;
  logic [NUM_CPU-1:0]  snoop_q, snoop_d;
  logic [NUM_CPU-1:0]  datasel_q, datasel_d;
  logic [NUM_CPU-1:0]  inv_q, inv_d;
  logic [NUM_CPU-1:0]  wb_q, wb_d;
  logic [NUM_CPU-1:0]  done_q, done_d;
  logic                busy_q, busy_d;

  logic [IW-1:0]       win_idx;
  logic [NUM_CPU-1:0]  peer_hit;
  logic [IW-1:0]       hit_idx;

  function automatic logic [NUM_CPU-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_CPU-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef SNOOP_BUS_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Offsets 1..NUM_CPU past the last winner; scanning downwards lets the nearest offset win.
  always_comb begin
    int unsigned idx;
    win_idx = '0;
    idx     = 0;
    for (int unsigned k = NUM_CPU; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NUM_CPU;
      if (req[idx]) win_idx = IW'(idx);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && |req) ptr_d = win_idx;
  end
`else
  always_comb begin
    win_idx = '0;
    for (int unsigned i = NUM_CPU; i >= 1; i--) begin
      if (req[i-1]) win_idx = IW'(i - 1);
    end
  end
`endif

  assign peer_hit = snoop_hit & ~grant_q;

  always_comb begin
    hit_idx = '0;
    for (int unsigned i = NUM_CPU; i >= 1; i--) begin
      if (peer_hit[i-1]) hit_idx = IW'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    fwd_d   = fwd_q;
    dirty_d = dirty_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = win_idx;
          op_d    = op_t'(req_op[2*win_idx +: 2]);
          addr_d  = req_addr[ADDR_W*win_idx +: ADDR_W];
          fwd_d   = '0;
          dirty_d = 1'b0;
          case (op_t'(req_op[2*win_idx +: 2]))
            OP_RD, OP_WR: begin
              state_d = S_SNOOP;
              cnt_d   = CW'(SNOOP_CYCLES - 1);
            end
            OP_INV:  state_d = S_INV;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_SNOOP: begin
        if (cnt_q == '0) begin
          dirty_d = |(snoop_dirty & ~grant_q);
          fwd_d   = hit_idx;
          cnt_d   = CW'(MEM_CYCLES - 1);
          if (op_q == OP_RD) begin
            state_d = (|peer_hit) ? S_FWD : S_MEM;
          end else begin
            state_d = (|(snoop_dirty & ~grant_q)) ? S_WB : S_MEM;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FWD: state_d = S_DONE;
      S_WB: begin
        if (cnt_q == '0) begin
          state_d = S_MEM;
          cnt_d   = CW'(MEM_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MEM: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_INV:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are registered alongside it.
  always_comb begin
    grant_d   = (state_d != S_IDLE) ? onehot(owner_d) : '0;
    snoop_d   = '0;
    datasel_d = '0;
    inv_d     = '0;
    wb_d      = '0;
    done_d    = '0;
    busy_d    = (state_d != S_IDLE);
    case (state_d)
      S_SNOOP: snoop_d = ~grant_d;
      S_FWD: begin
        datasel_d = grant_d;
        if (dirty_d) wb_d = onehot(fwd_d);
      end
      S_WB:  wb_d = onehot(fwd_d);
      S_INV: begin
        inv_d = ~grant_d;
        wb_d  = grant_d;
      end
      S_DONE: begin
        done_d = grant_d;
        if (op_d == OP_WR) inv_d = ~grant_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_RD;
      cnt_q     <= '0;
      owner_q   <= '0;
      addr_q    <= '0;
      fwd_q     <= '0;
      dirty_q   <= 1'b0;
      grant_q   <= '0;
      snoop_q   <= '0;
      datasel_q <= '0;
      inv_q     <= '0;
      wb_q      <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
`ifdef SNOOP_BUS_RR_EN
      ptr_q     <= IW'(NUM_CPU - 1);
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      fwd_q     <= fwd_d;
      dirty_q   <= dirty_d;
      grant_q   <= grant_d;
      snoop_q   <= snoop_d;
      datasel_q <= datasel_d;
      inv_q     <= inv_d;
      wb_q      <= wb_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef SNOOP_BUS_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign grant          = grant_q;
  assign addr_out       = addr_q;
  assign snoop          = snoop_q;
  assign datasel        = datasel_q;
  assign fwd_src        = fwd_q;
  assign invalidate_tag = inv_q;
  assign wback_dmem     = wb_q;
  assign done           = done_q;
  assign busy           = busy_q;

endmodule
